// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among R writeback sources, with forwarding hits.
// Grant is combinational and the write port is registered one cycle later; the register file never backpressures.
module regfile_write_arbiter #(
  parameter int B  = 32,
  parameter int N  = 5,
  parameter int R  = 2,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_addr,
  input  logic [R*B-1:0] req_data,
  output logic [R-1:0]   req_ready,
  output logic [N-1:0]   w_addr,
  output logic [B-1:0]   w_data,
  output logic           write_en,
  input  logic [N-1:0]   r_addr1,
  input  logic [N-1:0]   r_addr2,
  output logic           fwd_hit1,
  output logic           fwd_hit2,
  output logic [B-1:0]   fwd_data,
  output logic [CW-1:0]  stall_cnt
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic [PW-1:0] ptr_nxt;
  logic [R-1:0]  grant;
  logic          accept;
  logic          stalled;
  logic [N-1:0]  sel_addr;
  logic [B-1:0]  sel_data;

  // Scan from the farthest offset down so the nearest valid index to ptr wins.
  always_comb begin
    grant  = '0;
    winner = '0;
    for (int k = R - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % R]) begin
        winner = PW'((int'(ptr) + k) % R);
      end
    end
    if (|req_valid) begin
      grant[winner] = 1'b1;
    end
  end

  assign req_ready = rst_n ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign stalled   = |(req_valid & ~req_ready);
  assign sel_addr  = req_addr[int'(winner) * N +: N];
  assign sel_data  = req_data[int'(winner) * B +: B];
  assign ptr_nxt   = PW'((int'(winner) + 1) % R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      w_addr    <= '0;
      w_data    <= '0;
      write_en  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (accept) begin
        w_addr   <= sel_addr;
        w_data   <= sel_data;
        // Register 0 is hardwired: the write is taken but never enabled.
        write_en <= (sel_addr != '0);
        ptr      <= ptr_nxt;
      end else begin
        write_en <= 1'b0;
      end
      if (stalled && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end

  assign fwd_hit1 = write_en && (w_addr == r_addr1);
  assign fwd_hit2 = write_en && (w_addr == r_addr2);
  assign fwd_data = w_data;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  localparam int B  = 32;
  localparam int N  = 5;
  localparam int R  = 2;
  localparam int CW = 3;
  localparam int SAT = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_addr;
  logic [R*B-1:0] req_data;
  logic [R-1:0]   req_ready;
  logic [N-1:0]   w_addr;
  logic [B-1:0]   w_data;
  logic           write_en;
  logic [N-1:0]   r_addr1;
  logic [N-1:0]   r_addr2;
  logic           fwd_hit1;
  logic           fwd_hit2;
  logic [B-1:0]   fwd_data;
  logic [CW-1:0]  stall_cnt;

  regfile_write_arbiter #(.B(B), .N(N), .R(R), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .write_en  (write_en),
    .r_addr1   (r_addr1),
    .r_addr2   (r_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data  (fwd_data),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] a;
    logic [B-1:0] d;
    logic         we;
  } wr_t;

  wr_t          sb[$];
  int           tests = 0;
  int           fails = 0;
  int           mptr = 0;
  int           mstall = 0;
  logic [N-1:0] last_a = '0;
  logic [B-1:0] last_d = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check the same-cycle grant, then the registered write.
  task automatic cycle(input string tag, input logic [1:0] v,
                       input logic [N-1:0] a0, input logic [B-1:0] d0,
                       input logic [N-1:0] a1, input logic [B-1:0] d1);
    logic [1:0] er;
    int         w;
    wr_t        e;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    #1;
    er = 2'b00;
    if (v[mptr])          w = mptr;
    else if (v[1 - mptr]) w = 1 - mptr;
    else                  w = -1;
    if (w >= 0) begin
      er[w] = 1'b1;
      e.a   = (w == 1) ? a1 : a0;
      e.d   = (w == 1) ? d1 : d0;
      e.we  = (e.a != '0);
      sb.push_back(e);
      mptr = 1 - w;
    end
    if (((v & ~er) != 2'b00) && (mstall < SAT)) mstall++;
    chk({tag, "_ready"}, 64'(req_ready), 64'(er));
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_we"},    64'(write_en), 64'(e.we));
      chk({tag, "_waddr"}, 64'(w_addr),   64'(e.a));
      chk({tag, "_wdata"}, 64'(w_data),   64'(e.d));
      last_a = e.a;
      last_d = e.d;
    end else begin
      chk({tag, "_we_idle"},    64'(write_en), 64'(0));
      chk({tag, "_waddr_hold"}, 64'(w_addr),   64'(last_a));
      chk({tag, "_wdata_hold"}, 64'(w_data),   64'(last_d));
    end
    chk({tag, "_stall"}, 64'(stall_cnt), 64'(mstall));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_addr  = {5'd3, 5'd2};
    req_data  = '0;
    r_addr1   = '0;
    r_addr2   = '0;
    #12;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_we",    64'(write_en),  64'(0));
    chk("rst_waddr", 64'(w_addr),    64'(0));
    chk("rst_wdata", 64'(w_data),    64'(0));
    chk("rst_stall", 64'(stall_cnt), 64'(0));
    req_valid = 2'b00;
    #1 rst_n = 1'b1;

    cycle("single", 2'b01, 5'd5, 32'h0000_1234, 5'd0, 32'h0);
    cycle("single_after", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);

    // ptr is 1 here, so the zero write by req1 brings it back to 0.
    cycle("zero", 2'b10, 5'd0, 32'h0, 5'd0, 32'hFFFF_FFFF);

    for (int i = 0; i < 4; i++) begin
      cycle($sformatf("cont%0d", i), 2'b11, 5'd2, 32'hA000_0000 + 32'(i), 5'd3, 32'hB000_0000 + 32'(i));
    end
    chk("cont_stall4", 64'(stall_cnt), 64'(4));

    for (int i = 0; i < 5; i++) begin
      cycle($sformatf("sat%0d", i), 2'b11, 5'd4, 32'h44, 5'd6, 32'h66);
    end
    chk("stall_saturated", 64'(stall_cnt), 64'(SAT));

    cycle("fwd", 2'b01, 5'd7, 32'h0000_DEAD, 5'd0, 32'h0);
    r_addr1 = 5'd7;
    r_addr2 = 5'd3;
    #1;
    chk("fwd_hit1", 64'(fwd_hit1), 64'(1));
    chk("fwd_hit2", 64'(fwd_hit2), 64'(0));
    chk("fwd_data", 64'(fwd_data), 64'(32'h0000_DEAD));
    cycle("fwd_idle", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("fwd_hit1_idle", 64'(fwd_hit1), 64'(0));

    r_addr1 = 5'd0;
    cycle("zero2", 2'b01, 5'd0, 32'h1111_1111, 5'd0, 32'h0);
    chk("fwd_zero_nohit", 64'(fwd_hit1), 64'(0));

    r_addr2 = 5'd9;
    cycle("w9", 2'b10, 5'd0, 32'h0, 5'd9, 32'h0000_0999);
    chk("w9_fwd2", 64'(fwd_hit2), 64'(1));
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("midrst_we",    64'(write_en),  64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    chk("midrst_waddr", 64'(w_addr),    64'(0));
    chk("midrst_stall", 64'(stall_cnt), 64'(0));
    chk("midrst_fwd2",  64'(fwd_hit2),  64'(0));
    #3;
    rst_n  = 1'b1;
    mptr   = 0;
    mstall = 0;
    last_a = '0;
    last_d = '0;
    sb.delete();
    cycle("post_rst", 2'b11, 5'd10, 32'hCAFE_0010, 5'd11, 32'hCAFE_0011);
    cycle("post_rst2", 2'b11, 5'd10, 32'hCAFE_0010, 5'd11, 32'hCAFE_0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among R writeback requesters, e.g. ALU result and load data.
- Uses valid/ready handshakes and round-robin arbitration.
- Drives the register file's write port from flops.
- Provides forwarding hits for the two read ports, so readers see a write that is still in flight.
- Sits between the execute/memory writeback sources and the register memory.

Parameters:
- B, 32, data width in bits; must match the register file.
- N, 5, address width in bits (2**N registers).
- R, 2, number of requesters; must be at least 2.
- CW, 16, width of the stall counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  R  per-requester write request
- req_addr  in  R*N  flattened destination addresses; requester i uses bits [i*N +: N]
- req_data  in  R*B  flattened write data; requester i uses bits [i*B +: B]
- req_ready  out  R  one-hot grant; a write is accepted when req_valid[i] and req_ready[i] are both 1
- w_addr  out  N  register file write address
- w_data  out  B  register file write data
- write_en  out  1  register file write enable
- r_addr1  in  N  read port 1 address, taken from the register file read side
- r_addr2  in  N  read port 2 address
- fwd_hit1  out  1  in-flight write matches r_addr1
- fwd_hit2  out  1  in-flight write matches r_addr2
- fwd_data  out  B  forwarding value; always equals w_data
- stall_cnt  out  CW  saturating count of cycles in which a valid requester was not granted

Behaviour:
- Reset, asynchronous on rst_n low:
  - write_en=0, w_addr=0, w_data=0, stall_cnt=0.
  - Round-robin pointer ptr=0.
  - req_ready forced to all-zeros for as long as rst_n is low.
- Arbitration (combinational):
  - Search req_valid starting at index ptr, then ptr+1 and so on, modulo R.
  - The first valid index found is the winner, and only req_ready[winner]=1.
  - If no requester is valid, req_ready=0.
  - Grant is available in the same cycle the request is valid; there is no backpressure from the register file.
- Write stage, one-cycle latency:
  - On the clock edge after acceptance: w_addr <= req_addr[winner], w_data <= req_data[winner].
  - write_en <= 1 if the address is nonzero, 0 if the address is 0.
  - With no acceptance: write_en <= 0, and w_addr/w_data hold their values.
  - The register file commits at the following edge, so at most one write is in flight.
- Register 0 is hardwired to zero:
  - Writes to address 0 are accepted (ready is given) and then discarded.
  - ptr still advances on these writes.
- Pointer: on acceptance, ptr <= (winner+1) mod R; otherwise ptr holds. This guarantees no requester waits more than R-1 grants.
- Forwarding (combinational):
  - fwd_hit1 = write_en and (w_addr == r_addr1); fwd_hit2 is the same against r_addr2.
  - Both hits are 0 when write_en=0.
  - Since write_en is never 1 for address 0, r_addr=0 never hits.
- stall_cnt:
  - Increments when at least one req_valid bit is set whose matching req_ready bit is 0.
  - Saturates at 2**CW-1; it does not wrap.
- Requester rules:
  - A requester holds valid, addr and data stable until it is granted.
  - Dropping valid before grant is allowed; the arbiter keeps no lock.
  - A requester granted in one cycle may request again in the next.
- Simultaneous events: back-to-back grants issue one write per cycle. A new grant in the same cycle a write is in flight is legal.
- Reset during operation: an in-flight write is cancelled (write_en goes to 0 immediately) and is never committed. ptr returns to 0.

Test Plan:
- Reset: assert rst_n=0 with req_valid=2'b11 -> req_ready=0, write_en=0, w_addr=0, stall_cnt=0.
- Single request: req0 addr=5, data=0x00001234 -> req_ready=2'b01 in the same cycle. Next cycle: write_en=1, w_addr=5, w_data=0x00001234. Cycle after: write_en=0.
- Contention: both requesters valid for 4 cycles (req0 addr 2, req1 addr 3), each holding until granted and re-requesting -> grants 0,1,0,1. w_addr sequence 2,3,2,3. stall_cnt=4.
- Address zero: req1 addr=0, data=0xFFFFFFFF -> req_ready=2'b10. Next cycle: write_en=0. ptr=0, so a following both-valid request grants req0.
- Forwarding: write to addr 7 with data 0x0000DEAD in flight, r_addr1=7, r_addr2=3 -> fwd_hit1=1, fwd_data=0x0000DEAD, fwd_hit2=0. Next idle cycle: fwd_hit1=0.
- Mid-operation reset: pulse rst_n low while write_en=1 for addr 9 -> write_en=0 immediately, with no edge needed. After release, both requesters valid -> req0 granted first.
